// File: rtl/md_sched_pkg.sv
// Shared types for the multiply/divide sequencer: state encodings, default
// latencies and the latched-operand record.
package md_sched_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } mdState_t;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  localparam int MD_DATA_W      = 32;

  typedef struct packed {
    logic [MD_DATA_W-1:0] a;
    logic [MD_DATA_W-1:0] b;
    logic                 isSigned;
  } mdOp_t;

  // Smallest counter width able to hold a latency value of n.
  function automatic int mdCntBits(input int n);
    int bits;
    bits = 1;
    while ((1 << bits) <= n) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// E-stage control/operand bundle into the mult/div sequencer and its status/HI/LO
// results back out. master = pipeline side, slave = md_sched.
interface md_sched_if;

  logic        start;
  logic        is_mu;
  logic        is_signed;
  logic        write_hl;
  logic        write_hi;
  logic        read_hi;
  logic        flush;
  logic        d_uses_md;
  logic [31:0] src_a;
  logic [31:0] src_b;

  logic        busy;
  logic        stall_md;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, is_mu, is_signed, write_hl, write_hi, read_hi,
    output flush, d_uses_md, src_a, src_b,
    input  busy, stall_md, rd_data, hi, lo
  );

  modport slave (
    input  start, is_mu, is_signed, write_hl, write_hi, read_hi,
    input  flush, d_uses_md, src_a, src_b,
    output busy, stall_md, rd_data, hi, lo
  );

endinterface

// File: rtl/md_arith.sv
// Combinational 64-bit product and truncating quotient/remainder of the latched operands.
// Latency 0; no handshake -- md_sched holds operands stable for the whole busy period.
module md_arith (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        isSigned,
  output logic [63:0] prod,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        bZero
);

  logic [63:0] aExt;
  logic [63:0] bExt;
  logic [31:0] aMag;
  logic [31:0] bMag;
  logic [31:0] bSafe;
  logic [31:0] qMag;
  logic [31:0] rMag;
  logic        aNeg;
  logic        bNeg;

  assign aNeg = isSigned & a[31];
  assign bNeg = isSigned & b[31];

  // Sign/zero extension to 64 bits makes the truncated product correct for both modes.
  assign aExt = aNeg ? {32'hFFFF_FFFF, a} : {32'd0, a};
  assign bExt = bNeg ? {32'hFFFF_FFFF, b} : {32'd0, b};
  assign prod = aExt * bExt;

  assign aMag  = aNeg ? (~a + 32'd1) : a;
  assign bMag  = bNeg ? (~b + 32'd1) : b;
  assign bZero = (b == 32'd0);
  assign bSafe = bZero ? 32'd1 : bMag;

  assign qMag = aMag / bSafe;
  assign rMag = aMag % bSafe;

  // Quotient sign follows the operand signs; remainder follows the dividend.
  // 0x80000000 / -1 wraps back to 0x80000000 with a zero remainder.
  assign quo = (aNeg ^ bNeg) ? (~qMag + 32'd1) : qMag;
  assign rem = aNeg ? (~rMag + 32'd1) : rMag;

endmodule

// File: rtl/md_sched.sv
// E-stage mult/div sequencer: latency counter, FSM and HI/LO registers.
// Busy for MULT_CYCLES/DIV_CYCLES after start; stall_md holds the D stage while busy.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  md_sched_if.slave  md
);

  if (MULT_CYCLES < 1 || DIV_CYCLES < 1 ||
      CNT_W < mdCntBits(MULT_CYCLES) || CNT_W < mdCntBits(DIV_CYCLES)) begin : gBadParam
    $error("md_sched: latencies must be >= 1 and fit in CNT_W bits");
  end

  mdState_t          state;
  mdState_t          stateNext;
  logic [CNT_W-1:0]  cnt;
  mdOp_t             op;
  logic [31:0]       hiReg;
  logic [31:0]       loReg;

  logic [63:0]       prod;
  logic [31:0]       quo;
  logic [31:0]       rem;
  logic              bZero;

  logic              busy;
  logic              startOk;
  logic              lastCycle;
  logic              hlWrite;

  assign busy      = (state != MD_IDLE);
  assign startOk   = (state == MD_IDLE) && md.start && !md.flush;
  assign lastCycle = busy && (cnt == CNT_W'(1));
  // A start in the same cycle suppresses mthi/mtlo even when that start is flushed.
  assign hlWrite   = (state == MD_IDLE) && md.write_hl && !md.flush && !md.start;

  md_arith uArith (
    .a        (op.a),
    .b        (op.b),
    .isSigned (op.isSigned),
    .prod     (prod),
    .quo      (quo),
    .rem      (rem),
    .bZero    (bZero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MD_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      MD_IDLE: begin
        if (startOk) begin
          stateNext = md.is_mu ? MD_MUL : MD_DIV;
        end
      end
      MD_MUL, MD_DIV: begin
        if (lastCycle) begin
          stateNext = MD_IDLE;
        end
      end
      default: stateNext = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      op    <= '0;
      hiReg <= '0;
      loReg <= '0;
    end else begin
      if (startOk) begin
        cnt <= md.is_mu ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        op  <= '{a: md.src_a, b: md.src_b, isSigned: md.is_signed};
      end else if (busy) begin
        cnt <= cnt - CNT_W'(1);
      end

      // Results land on the edge that closes the busy window; divide by zero keeps HI/LO.
      if (lastCycle && state == MD_MUL) begin
        hiReg <= prod[63:32];
        loReg <= prod[31:0];
      end else if (lastCycle && state == MD_DIV && !bZero) begin
        hiReg <= rem;
        loReg <= quo;
      end else if (hlWrite) begin
        if (md.write_hi) begin
          hiReg <= md.src_a;
        end else begin
          loReg <= md.src_a;
        end
      end
    end
  end

  assign md.busy     = busy;
  assign md.stall_md = md.d_uses_md & (busy | (md.start & !md.flush));
  assign md.rd_data  = md.read_hi ? hiReg : loReg;
  assign md.hi       = hiReg;
  assign md.lo       = loReg;

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequencing controller for the multiply/divide resource and the HI/LO register pair in the P7 MIPS pipeline. Sits in the E stage.
- Accepts mult/multu/div/divu starts and mthi/mtlo writes from the decoded E-stage control signals.
- Models multi-cycle latency with a down-counter and holds HI/LO. Produces busy, the D-stage stall request and the HI/LO read value.
- A start that coincides with an exception/interrupt flush is dropped. An operation already in flight always completes.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (must be >=1)
DIV_CYCLES, 10, busy cycles for div/divu (must be >=1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  E-stage instruction is mult/multu/div/divu
is_mu  in  1  start is a multiply (else divide)
is_signed  in  1  signed variant (mult/div)
write_hl  in  1  E-stage mthi/mtlo
write_hi  in  1  with write_hl: 1=mthi, 0=mtlo
read_hi  in  1  read select for rd_data: 1=HI, 0=LO
flush  in  1  E-stage instruction cancelled by exception/interrupt this cycle
d_uses_md  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
src_a  in  32  rs operand (forwarded)
src_b  in  32  rt operand (forwarded)
busy  out  1  operation in flight
stall_md  out  1  D-stage stall request
rd_data  out  32  HI or LO per read_hi, for mfhi/mflo
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (reset==0 at posedge): state IDLE, counter 0, HI=0, LO=0, busy=0. Pending results are discarded. Reset dominates all other inputs, including mid-operation.
- States: IDLE, MUL_BUSY, DIV_BUSY.
- IDLE, start & !flush: operands and signedness are latched, cnt=MULT_CYCLES or DIV_CYCLES, next state MUL_BUSY/DIV_BUSY. start & flush: stays IDLE, no effect.
- Busy states: cnt decrements each cycle. At the cycle where cnt==1, HI/LO are written at that edge and the next state is IDLE.
- busy=1 exactly N consecutive cycles, starting the cycle after start. The new HI/LO is visible the first cycle busy==0.
- flush while busy: ignored; the operation completes.
- Multiply: 64-bit product of the latched operands, signed or unsigned. HI=prod[63:32], LO=prod[31:0].
- Divide: LO=quotient, HI=remainder, truncated toward zero. The remainder takes the sign of the dividend in signed mode.
- Divide with src_b==0: HI/LO left unchanged; the busy period still elapses.
- Signed 0x80000000 / -1: LO=0x80000000, HI=0.
- write_hl & !flush & !busy & !start: HI (write_hi) or LO takes src_a at the edge, visible next cycle.
- write_hl while busy: ignored (prevented upstream by stall_md).
- write_hl together with start: start wins.
- stall_md = d_uses_md & (busy | (start & !flush)). Purely combinational, no registered delay.
- rd_data = read_hi ? HI : LO. Combinational from the registers; no bypass of an in-flight result.
- start is only sampled in IDLE. A start while busy is an upstream protocol violation and is ignored.

Decomposition:
- Shared macro header entries: state encodings (MD_IDLE, MD_MUL, MD_DIV) and default latencies (MULT_CYCLES, DIV_CYCLES), next to the existing instruction-bus defines.
- One sub-module: md_arith. Purely combinational 64-bit mult and div/rem from latched operands, plus signedness and the b==0 flag.
- Counter, FSM and HI/LO registers stay in md_sched.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-div → busy=0, hi=lo=0, stall_md=0.
- mult signed, a=0xFFFFFFFE (-2), b=3 → busy high 5 cycles. Then hi=0xFFFFFFFF, lo=0xFFFFFFFA. stall_md=1 on cycles with d_uses_md during busy.
- divu, a=17, b=5 → busy 10 cycles, then lo=3, hi=2.
- div signed, a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div by zero after mthi 0x1234/mtlo 0x5678 → busy 10 cycles; hi=0x1234, lo=0x5678 unchanged.
- start with flush=1 → busy stays 0, HI/LO unchanged.
- Flush on cycle 3 of a mult → still completes at cycle 5 with the correct product.
